// File: rtl/gpio_irq_if.sv
// slave_bus_if: byte-register slave bus used by gpio_irq.
// ttype = 1 marks a write; any other access is a read. The slave answers
// every access in the same cycle, so bdone is a constant handshake.
interface slave_bus_if;
    logic        ss;     // slave select
    logic        ttype;  // 1 = WRITE, 0 = READ
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        bdone;

    modport slave (
        input  ss,
        input  ttype,
        input  addr,
        input  wdata,
        output rdata,
        output bdone
    );

    modport master (
        output ss,
        output ttype,
        output addr,
        output wdata,
        input  rdata,
        input  bdone
    );
endinterface

// File: rtl/gpio_irq.sv
// gpio_irq: synchronises raw GPIO pin inputs, detects per-pin rising and
// falling edges, latches them in a write-1-to-clear PENDING register and
// drives a single level interrupt.
//
// Optional feature macro: GPIO_IRQ_DEBOUNCE_EN
//   defined   -> per-pin debounce counter between the synchroniser and the
//                conditioned level, threshold programmable at offset 0x14.
//   undefined -> level is the synchroniser output; 0x14 reads 0.
module gpio_irq #(
    parameter int N_PINS   = 8,
    parameter int DB_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    slave_bus_if.slave        bus,
    input  logic [N_PINS-1:0] pin_in,
    output logic              irq
);

    localparam logic       TT_WRITE    = 1'b1;
    localparam logic [7:0] OFF_LEVEL   = 8'h00;
    localparam logic [7:0] OFF_IRQ_EN  = 8'h04;
    localparam logic [7:0] OFF_RISE_EN = 8'h08;
    localparam logic [7:0] OFF_FALL_EN = 8'h0C;
    localparam logic [7:0] OFF_PENDING = 8'h10;
    localparam logic [7:0] OFF_DB_CNT  = 8'h14;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [7:0]        off;
    logic              wr_en;
    logic [N_PINS-1:0] wr_bits;
    logic              we_irq_en;
    logic              we_rise_en;
    logic              we_fall_en;
    logic              we_pending;

    assign off        = bus.addr[7:0];
    assign wr_en      = bus.ss && (bus.ttype == TT_WRITE);
    assign wr_bits    = bus.wdata[N_PINS-1:0];
    assign we_irq_en  = wr_en && (off == OFF_IRQ_EN);
    assign we_rise_en = wr_en && (off == OFF_RISE_EN);
    assign we_fall_en = wr_en && (off == OFF_FALL_EN);
    assign we_pending = wr_en && (off == OFF_PENDING);

    // ------------------------------------------------------------------
    // Synchroniser and warm-up
    // ------------------------------------------------------------------
    logic [N_PINS-1:0] s1;
    logic [N_PINS-1:0] s2;
    logic [1:0]        warm_cnt;
    logic              warm_done;

    // Two-flop synchroniser: pin_in is asynchronous to clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            // NOTE: non-blocking so s2 captures the previous s1, giving a real
            // two-stage chain; blocking here would collapse it into one flop.
            s1 <= pin_in;
            s2 <= s1;
        end
    end

    assign warm_done = (warm_cnt == 2'd3);

    // Warm-up counter: edge events are masked until the pipeline has filled.
    always_ff @(posedge clk) begin
        if (rst) begin
            warm_cnt <= 2'd0;
        end else if (!warm_done) begin
            warm_cnt <= warm_cnt + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Conditioned level (optionally debounced)
    // ------------------------------------------------------------------
    logic [N_PINS-1:0] level;

`ifdef GPIO_IRQ_DEBOUNCE_EN
    logic [DB_WIDTH-1:0] db_cnt;
    logic [DB_WIDTH-1:0] db_ctr [N_PINS];
    logic [N_PINS-1:0]   stable;
    logic                we_db_cnt;

    assign we_db_cnt = wr_en && (off == OFF_DB_CNT);

    // Debounce threshold register.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt <= '0;
        end else if (we_db_cnt) begin
            db_cnt <= DB_WIDTH'(bus.wdata[7:0]);
        end
    end

    // Per-pin debounce: s2 must differ from stable for db_cnt+1 cycles in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= '0;
            // NOTE: the counter array is a handful of flops, not a RAM, so it
            // is cleared in reset like any other register.
            for (int i = 0; i < N_PINS; i++) begin
                db_ctr[i] <= '0;
            end
        end else if (!warm_done) begin
            // Preloading from s1 lets stable settle one cycle ahead of prev,
            // so a pin held high through reset never looks like a rising edge.
            stable <= s1;
            for (int i = 0; i < N_PINS; i++) begin
                db_ctr[i] <= '0;
            end
        end else if (we_db_cnt) begin
            for (int i = 0; i < N_PINS; i++) begin
                db_ctr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_PINS; i++) begin
                if (s2[i] == stable[i]) begin
                    db_ctr[i] <= '0;
                end else if (db_ctr[i] == db_cnt) begin
                    stable[i] <= s2[i];
                    db_ctr[i] <= '0;
                end else begin
                    db_ctr[i] <= db_ctr[i] + DB_WIDTH'(1);
                end
            end
        end
    end

    assign level = stable;
`else
    logic unused_cfg;

    assign level      = s2;
    assign unused_cfg = 1'(DB_WIDTH);
`endif

    // ------------------------------------------------------------------
    // Edge detection, enables and pending
    // ------------------------------------------------------------------
    logic [N_PINS-1:0] prev;
    logic [N_PINS-1:0] rise;
    logic [N_PINS-1:0] fall;
    logic [N_PINS-1:0] edge_evt;
    logic [N_PINS-1:0] clr_bits;
    logic [N_PINS-1:0] irq_en;
    logic [N_PINS-1:0] rise_en;
    logic [N_PINS-1:0] fall_en;
    logic [N_PINS-1:0] pending;

    // prev follows level every cycle, warm-up included.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '0;
        end else begin
            prev <= level;
        end
    end

    assign rise     = level & ~prev;
    assign fall     = ~level & prev;
    assign edge_evt = warm_done ? ((rise & rise_en) | (fall & fall_en)) : '0;
    assign clr_bits = we_pending ? wr_bits : '0;

    // Software-programmed enable registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en  <= '0;
            rise_en <= '0;
            fall_en <= '0;
        end else begin
            if (we_irq_en) begin
                irq_en <= wr_bits;
            end
            if (we_rise_en) begin
                rise_en <= wr_bits;
            end
            if (we_fall_en) begin
                fall_en <= wr_bits;
            end
        end
    end

    // Pending latch: a new edge wins over a same-cycle write-1-to-clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_bits) | edge_evt;
        end
    end

    assign irq = |(pending & irq_en);

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [31:0] rdata_c;

    // Read data is a pure function of the address; reads have no side effects.
    always_comb begin
        // NOTE: default assignment first so every path drives rdata_c and no
        // latch is inferred for unlisted offsets.
        rdata_c = '0;
        case (off)
            OFF_LEVEL:   rdata_c = 32'(level);
            OFF_IRQ_EN:  rdata_c = 32'(irq_en);
            OFF_RISE_EN: rdata_c = 32'(rise_en);
            OFF_FALL_EN: rdata_c = 32'(fall_en);
            OFF_PENDING: rdata_c = 32'(pending);
`ifdef GPIO_IRQ_DEBOUNCE_EN
            OFF_DB_CNT:  rdata_c = 32'(db_cnt);
`endif
            default:     rdata_c = '0;
        endcase
    end

    assign bus.rdata = rdata_c;
    assign bus.bdone = 1'b1;

    // Only the low address byte is decoded and only wdata[7:0] carries data.
    logic unused_bus;
    assign unused_bus = ^{bus.addr[31:8], bus.wdata[31:8]};

endmodule
